// File: rtl/gpio_in_debounce_irq.sv
// rtl/gpio_in_debounce_irq.sv - GPIO input synchroniser, debouncer, sticky edge status and interrupt
//
// Ports:
//   clk_i         sole clock, rising edge
//   rst_ni        synchronous active-low reset
//   gpio_i        raw pin values, asynchronous to clk_i
//   rise_en_i     per-pin rising-edge capture enable
//   fall_en_i     per-pin falling-edge capture enable
//   irq_mask_i    per-pin interrupt mask, 1 = masked
//   status_clr_i  write-1-to-clear pulse for status bits
//   gpio_o        debounced pin state
//   status_o      sticky edge-event status
//   irq_o         registered level interrupt request
module gpio_in_debounce_irq #(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gpio_i,
    input  logic [WIDTH-1:0] rise_en_i,
    input  logic [WIDTH-1:0] fall_en_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    input  logic [WIDTH-1:0] status_clr_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] status_o,
    output logic             irq_o
);

    // Terminal count: the DEBOUNCE_CYCLES-th consecutive cycle of disagreement
    // between the synchronised pin and the debounced value is the accept cycle.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic [WIDTH-1:0] gpio_q;
    logic [WIDTH-1:0] status_q;
    logic             irq_q;

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] status_d;
    logic             irq_d;

    // Per-pin stability counter. Any cycle where the synchronised value
    // agrees with the debounced value restarts the count, so a glitch
    // shorter than DEBOUNCE_CYCLES leaves no trace.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q2[i] != gpio_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge events coincide with the debounced-value update edge.
    assign rise = accept & sync_q2;
    assign fall = accept & ~sync_q2;

    // New events win over a coincident clear.
    assign status_d = (status_q & ~status_clr_i)
                    | (rise & rise_en_i)
                    | (fall & fall_en_i);

    // Built from the registered status, so irq_o trails status_o by a cycle.
    assign irq_d = |(status_q & ~irq_mask_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            gpio_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q1  <= gpio_i;
            sync_q2  <= sync_q1;
            gpio_q   <= gpio_q ^ accept;
            status_q <= status_d;
            irq_q    <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_o   = gpio_q;
    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce_irq.sv
// tb/tb_gpio_in_debounce_irq.sv - self-checking bench for gpio_in_debounce_irq
module tb_gpio_in_debounce_irq;

    localparam int W  = 8;
    localparam int DC = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [W-1:0] gpio_i;
    logic [W-1:0] rise_en_i;
    logic [W-1:0] fall_en_i;
    logic [W-1:0] irq_mask_i;
    logic [W-1:0] status_clr_i;
    logic [W-1:0] gpio_o;
    logic [W-1:0] status_o;
    logic         irq_o;

    always #5 clk_i = ~clk_i;

    gpio_in_debounce_irq #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .gpio_i       (gpio_i),
        .rise_en_i    (rise_en_i),
        .fall_en_i    (fall_en_i),
        .irq_mask_i   (irq_mask_i),
        .status_clr_i (status_clr_i),
        .gpio_o       (gpio_o),
        .status_o     (status_o),
        .irq_o        (irq_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a pin is accepted when the last DC synchronised
    // samples all disagree with the current debounced value.
    logic [W-1:0] m_q1     = '0;
    logic [W-1:0] m_q2     = '0;
    logic [W-1:0] m_out    = '0;
    logic [W-1:0] m_status = '0;
    logic         m_irq    = 1'b0;
    logic [W-1:0] m_win[$];

    typedef struct {
        logic         rst;
        logic [W-1:0] gpio;
        logic [W-1:0] clr;
        logic [W-1:0] egpio;
        logic [W-1:0] estat;
        logic         eirq;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [W-1:0] acc;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        if (!rst_ni) begin
            m_q1 = '0; m_q2 = '0; m_out = '0; m_status = '0; m_irq = 1'b0;
            m_win.delete();
        end else begin
            m_win.push_back(m_q2);
            if (m_win.size() > DC) void'(m_win.pop_front());
            acc = '0;
            if (m_win.size() == DC) begin
                acc = '1;
                foreach (m_win[k]) acc &= (m_win[k] ^ m_out);
            end
            rise     = acc & m_q2;
            fall     = acc & ~m_q2;
            m_irq    = |(m_status & ~irq_mask_i);
            m_status = (m_status & ~status_clr_i) | (rise & rise_en_i) | (fall & fall_en_i);
            m_out    = m_out ^ acc;
            m_q2     = m_q1;
            m_q1     = gpio_i;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_edge();
        #1;
        chk("model_gpio_o", gpio_o, m_out);
        chk("model_status_o", status_o, m_status);
        chk("model_irq_o", W'(irq_o), W'(m_irq));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; gpio_i = '0; rise_en_i = '1; fall_en_i = '1;
        irq_mask_i = '0; status_clr_i = '0;
        tick(); tick();
        rst_ni = 1'b1;
    endtask

    initial begin
        int           n;
        logic         found;
        logic [W-1:0] seen;
        logic [W-1:0] st_at;

        // Reset, power-up notification, clear-all, fall, set-wins, clear.
        for (int r = 0; r < 3; r++)   tbl[r] = '{1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        for (int r = 3; r < 8; r++)   tbl[r] = '{1'b1, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b0};
        tbl[9]  = '{1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5, 1'b1};
        tbl[10] = '{1'b1, 8'hA5, 8'hFF, 8'hA5, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0};
        for (int r = 12; r < 17; r++) tbl[r] = '{1'b1, 8'hA4, 8'h00, 8'hA5, 8'h00, 1'b0};
        tbl[17] = '{1'b1, 8'hA4, 8'h00, 8'hA4, 8'h01, 1'b0};
        tbl[18] = '{1'b1, 8'hA5, 8'h00, 8'hA4, 8'h01, 1'b1};
        for (int r = 19; r < 23; r++) tbl[r] = '{1'b1, 8'hA5, 8'h00, 8'hA4, 8'h01, 1'b1};
        tbl[23] = '{1'b1, 8'hA5, 8'h01, 8'hA5, 8'h01, 1'b1};
        tbl[24] = '{1'b1, 8'hA5, 8'h01, 8'hA5, 8'h00, 1'b1};
        tbl[25] = '{1'b1, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0};

        rise_en_i = '1; fall_en_i = '1; irq_mask_i = '0;
        for (int r = 0; r < 26; r++) begin
            rst_ni = tbl[r].rst; gpio_i = tbl[r].gpio; status_clr_i = tbl[r].clr;
            tick();
            chk($sformatf("tbl%0d_gpio_o", r), gpio_o, tbl[r].egpio);
            chk($sformatf("tbl%0d_status_o", r), status_o, tbl[r].estat);
            chk($sformatf("tbl%0d_irq_o", r), W'(irq_o), W'(tbl[r].eirq));
        end

        // Glitch of 3 cycles is rejected, then a held rise is accepted on edge 6.
        do_reset();
        seen = '0;
        gpio_i = 8'h01;
        repeat (3) begin tick(); seen |= gpio_o | status_o | W'(irq_o); end
        gpio_i = 8'h00;
        repeat (10) begin tick(); seen |= gpio_o | status_o | W'(irq_o); end
        chk("glitch_reject", seen, 8'h00);
        gpio_i = 8'h01;
        found = 1'b0; n = 0; st_at = '0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            if (gpio_o[0]) begin found = 1'b1; n = k; st_at = status_o; end
        end
        chk("glitch_found", W'(found), 8'h01);
        chk("glitch_latency", W'(n), 8'd6);
        chk("glitch_status", st_at, 8'h01);

        // Enables gate events only.
        do_reset();
        rise_en_i = 8'h00; fall_en_i = 8'h02;
        gpio_i = 8'h02; seen = '0;
        repeat (10) begin tick(); seen |= status_o; end
        chk("en_rise_gated", seen, 8'h00);
        chk("en_gpio_hi", gpio_o, 8'h02);
        gpio_i = 8'h00;
        repeat (10) begin
            tick();
            chk("en_fall_track", status_o, gpio_o[1] ? 8'h00 : 8'h02);
        end
        chk("en_gpio_lo", gpio_o, 8'h00);
        rise_en_i = 8'hFF; fall_en_i = 8'h00;
        tick();
        chk("en_change_keep", status_o, 8'h02);

        // Mask drops irq without touching status; unmask restores it.
        do_reset();
        gpio_i = 8'h10;
        repeat (7) tick();
        chk("mask_status_pre", status_o, 8'h10);
        chk("mask_irq_pre", W'(irq_o), 8'h01);
        irq_mask_i = 8'h10;
        tick();
        chk("mask_irq_off", W'(irq_o), 8'h00);
        chk("mask_status_kept", status_o, 8'h10);
        irq_mask_i = 8'h00;
        tick();
        chk("mask_irq_on", W'(irq_o), 8'h01);

        // All pins rise together.
        do_reset();
        tick(); tick();
        gpio_i = 8'hFF;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k < 6) begin
                chk("multi_gpio_wait", gpio_o, 8'h00);
                chk("multi_status_wait", status_o, 8'h00);
            end else if (k == 6) begin
                chk("multi_gpio", gpio_o, 8'hFF);
                chk("multi_status", status_o, 8'hFF);
                chk("multi_irq_wait", W'(irq_o), 8'h00);
            end else begin
                chk("multi_irq", W'(irq_o), 8'h01);
            end
        end

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_ni = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 7) == 0) gpio_i[b] = ~gpio_i[b];
            end
            if ($urandom_range(0, 15) == 0) rise_en_i  = W'($urandom);
            if ($urandom_range(0, 15) == 0) fall_en_i  = W'($urandom);
            if ($urandom_range(0, 15) == 0) irq_mask_i = W'($urandom);
            status_clr_i = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
